// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI link bridge: command opcodes, decoder
// states, the filler byte returned when no real data is available, and
// the burst-length decode helper.
package spi_link_pkg;

    typedef enum logic [3:0] {
        OP_REG     = 4'h9,
        OP_FIFO_RD = 4'hA,
        OP_FIFO_WR = 4'hB,
        OP_CLR     = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        REG_ADDR,
        REG_DATA,
        REG_PAD,
        RD_LEN,
        RD_BURST,
        WR_LEN,
        WR_BURST
    } state_e;

    localparam logic [7:0] UNDERRUN_BYTE = 8'h00;

    // A length byte of zero encodes a full 256-byte burst.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_link_bridge_if.sv
// Byte-stream link between the SPI slave PHY and the bridge.
//   spi_data/valid           : received byte and its one-cycle strobe
//   spi_data_out/spi_tx_valid: byte to load into SPI TX and its strobe
// master = SPI slave PHY side, slave = bridge side.
interface spi_link_bridge_if;

    logic [7:0] spi_data;
    logic       valid;
    logic [7:0] spi_data_out;
    logic       spi_tx_valid;

    modport master (
        output spi_data,
        output valid,
        input  spi_data_out,
        input  spi_tx_valid
    );

    modport slave (
        input  spi_data,
        input  valid,
        output spi_data_out,
        output spi_tx_valid
    );

endinterface

// File: rtl/spi_link_watchdog.sv
// Inter-byte timeout for the SPI link bridge (used only when the bridge is
// built with SPI_LINK_TIMEOUT_EN).
//   clk, rst : clock and synchronous active-high reset
//   kick     : received-byte strobe, restarts the count
//   busy     : bridge is mid-transaction; counting only happens while high
//   expire   : high for one cycle after TIMEOUT_CYC idle busy cycles
module spi_link_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic busy,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt;

    assign expire = busy && !kick && (cnt == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || kick || !busy || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_link_bridge.sv
// Decodes the SPI byte stream into register accesses and burst FIFO
// transfers towards up to N_TGT targets.
//   clk, rst         : clock, synchronous active-high reset
//   spi              : byte stream to/from the SPI slave (slave modport)
//   tgt_addr/_data_o : shared register address / write data
//   tgt_we           : one-hot register write strobe
//   tgt_data_i       : per-target register read data (comb. from tgt_addr)
//   fifo_rd/_rdata   : one-hot pop strobe, head data valid the next cycle
//   fifo_we/_wdata   : one-hot push strobe, shared push data
//   fifo_empty/_full : per-target FIFO flags
//   busy             : decoder not idle
//   err_underrun/_overflow : sticky error flags, cleared by the CLR command
// Optional: define SPI_LINK_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC cycles without a received byte.
module spi_link_bridge
    import spi_link_pkg::*;
#(
    parameter int unsigned N_TGT       = 4,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_link_bridge_if.slave     spi,
    output logic [ADDR_W-1:0]    tgt_addr,
    output logic [7:0]           tgt_data_o,
    output logic [N_TGT-1:0]     tgt_we,
    input  logic [N_TGT*8-1:0]   tgt_data_i,
    output logic [N_TGT-1:0]     fifo_rd,
    input  logic [N_TGT*8-1:0]   fifo_rdata,
    input  logic [N_TGT-1:0]     fifo_empty,
    output logic [N_TGT-1:0]     fifo_we,
    output logic [7:0]           fifo_wdata,
    input  logic [N_TGT-1:0]     fifo_full,
    output logic                 busy,
    output logic                 err_underrun,
    output logic                 err_overflow
);

    state_e     state;
    logic [2:0] tgt;
    logic [8:0] count;
    logic       rw;
    logic       reg_rd_pend;
    // Two-stage FIFO read pipeline: pop strobe, then head data arrives.
    logic       fetch1, fetch1_zero, fetch2, fetch2_zero;

    logic [N_TGT-1:0] tgt_hot;
    logic             tgt_ok, sel_empty, sel_full;
    logic [7:0]       sel_reg, sel_fifo;
    logic             do_fetch, set_under, set_over, clr_err, timeout;

    // An out-of-range target yields an all-zero one-hot, which silences
    // every strobe and error for it.
    always_comb begin
        tgt_hot  = '0;
        sel_reg  = '0;
        sel_fifo = '0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (tgt == 3'(i)) begin
                tgt_hot[i] = 1'b1;
                sel_reg    = tgt_data_i[i*8 +: 8];
                sel_fifo   = fifo_rdata[i*8 +: 8];
            end
        end
    end

    assign tgt_ok    = |tgt_hot;
    assign sel_empty = |(fifo_empty & tgt_hot);
    assign sel_full  = |(fifo_full & tgt_hot);
    assign busy      = (state != IDLE);

    // Fetch on the length byte and on every burst byte except the last.
    assign do_fetch  = spi.valid && ((state == RD_LEN) || (state == RD_BURST && count > 9'd1));
    assign set_under = do_fetch && tgt_ok && sel_empty;
    assign set_over  = spi.valid && (state == WR_BURST) && tgt_ok && sel_full;
    assign clr_err   = spi.valid && (state == IDLE) && spi.spi_data[7]
                       && (spi.spi_data[3:0] == OP_CLR);

`ifdef SPI_LINK_TIMEOUT_EN
    spi_link_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .kick   (spi.valid),
        .busy   (busy),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tgt              <= '0;
            count            <= '0;
            rw               <= 1'b0;
            reg_rd_pend      <= 1'b0;
            fetch1           <= 1'b0;
            fetch1_zero      <= 1'b0;
            fetch2           <= 1'b0;
            fetch2_zero      <= 1'b0;
            tgt_addr         <= '0;
            tgt_data_o       <= '0;
            tgt_we           <= '0;
            fifo_rd          <= '0;
            fifo_we          <= '0;
            fifo_wdata       <= '0;
            spi.spi_data_out <= '0;
            spi.spi_tx_valid <= 1'b0;
            err_underrun     <= 1'b0;
            err_overflow     <= 1'b0;
        end else begin
            tgt_we           <= '0;
            fifo_rd          <= '0;
            fifo_we          <= '0;
            spi.spi_tx_valid <= 1'b0;
            reg_rd_pend      <= 1'b0;
            fetch1           <= do_fetch;
            fetch1_zero      <= !tgt_ok || sel_empty;
            fetch2           <= fetch1;
            fetch2_zero      <= fetch1_zero;
            // Setting wins over a simultaneous clear.
            err_underrun     <= set_under | (err_underrun & ~clr_err);
            err_overflow     <= set_over | (err_overflow & ~clr_err);

            if (timeout) begin
                state <= IDLE;
                count <= '0;
            end else begin
                if (reg_rd_pend) begin
                    spi.spi_data_out <= tgt_ok ? sel_reg : UNDERRUN_BYTE;
                    spi.spi_tx_valid <= 1'b1;
                end
                if (fetch2) begin
                    spi.spi_data_out <= fetch2_zero ? UNDERRUN_BYTE : sel_fifo;
                    spi.spi_tx_valid <= 1'b1;
                end
                if (do_fetch && tgt_ok && !sel_empty) begin
                    fifo_rd <= tgt_hot;
                end

                if (spi.valid) begin
                    unique case (state)
                        IDLE: begin
                            if (spi.spi_data[7]) begin
                                tgt <= spi.spi_data[6:4];
                                case (spi.spi_data[3:0])
                                    OP_REG:     state <= REG_ADDR;
                                    OP_FIFO_RD: state <= RD_LEN;
                                    OP_FIFO_WR: state <= WR_LEN;
                                    default:    ;
                                endcase
                            end
                        end
                        REG_ADDR: begin
                            tgt_addr    <= spi.spi_data[ADDR_W-1:0];
                            rw          <= spi.spi_data[7];
                            reg_rd_pend <= !spi.spi_data[7];
                            state       <= REG_DATA;
                        end
                        REG_DATA: begin
                            if (rw) begin
                                tgt_data_o <= spi.spi_data;
                                tgt_we     <= tgt_hot;
                            end
                            state <= REG_PAD;
                        end
                        REG_PAD: state <= IDLE;
                        RD_LEN: begin
                            count <= len_to_count(spi.spi_data);
                            state <= RD_BURST;
                        end
                        RD_BURST: begin
                            count <= count - 9'd1;
                            if (count == 9'd1) state <= IDLE;
                        end
                        WR_LEN: begin
                            count <= len_to_count(spi.spi_data);
                            state <= WR_BURST;
                        end
                        WR_BURST: begin
                            if (tgt_ok && !sel_full) begin
                                fifo_we    <= tgt_hot;
                                fifo_wdata <= spi.spi_data;
                            end
                            count <= count - 9'd1;
                            if (count == 9'd1) state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
